// File: rtl/keypad_encoder.sv
// 4x4 matrix keypad scanner: drives rows one-cold, debounces a single key press
// and release, and encodes the accepted key as a 4-bit hex code on x3..x0.
module keypad_encoder #(
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned DEBOUNCE = 500000,
    parameter int unsigned CNT_W    = 20
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic       x3,
    output logic       x2,
    output logic       x1,
    output logic       x0,
    output logic       key_valid,
    output logic       key_held
);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE);

    state_t           state, state_nxt;
    logic [1:0]       row_idx, row_idx_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic [1:0]       cand_row, cand_row_nxt;
    logic [3:0]       cand_cols, cand_cols_nxt;
    logic [3:0]       code, code_nxt;
    logic             key_valid_nxt, key_held_nxt;
    logic [3:0]       col_meta, cols;
    logic [3:0]       low;
    logic             single;

    // Row/column position to keypad legend "1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D".
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [3:0] cc);
        logic [1:0] c;
        logic [3:0] res;
        if (!cc[0])      c = 2'd0;
        else if (!cc[1]) c = 2'd1;
        else if (!cc[2]) c = 2'd2;
        else             c = 2'd3;
        case ({r, c})
            4'h0: res = 4'h1;  4'h1: res = 4'h2;  4'h2: res = 4'h3;  4'h3: res = 4'hA;
            4'h4: res = 4'h4;  4'h5: res = 4'h5;  4'h6: res = 4'h6;  4'h7: res = 4'hB;
            4'h8: res = 4'h7;  4'h9: res = 4'h8;  4'hA: res = 4'h9;  4'hB: res = 4'hC;
            4'hC: res = 4'hE;  4'hD: res = 4'h0;  4'hE: res = 4'hF;  default: res = 4'hD;
        endcase
        return res;
    endfunction

    // Two-flop synchronizer; idle columns read high.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            col_meta <= 4'b1111;
            cols     <= 4'b1111;
        end else begin
            col_meta <= col_n;
            cols     <= col_meta;
        end
    end

    // Exactly one low column counts as a key; anything else is ignored.
    assign low     = ~cols;
    assign single  = (low != 4'b0000) && ((low & (low - 4'd1)) == 4'b0000);
    assign cnt_inc = cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_SCAN;
            row_idx   <= 2'd0;
            cnt       <= '0;
            cand_row  <= 2'd0;
            cand_cols <= 4'b1111;
            code      <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            row_n     <= 4'b1110;
        end else begin
            state     <= state_nxt;
            row_idx   <= row_idx_nxt;
            cnt       <= cnt_nxt;
            cand_row  <= cand_row_nxt;
            cand_cols <= cand_cols_nxt;
            code      <= code_nxt;
            key_valid <= key_valid_nxt;
            key_held  <= key_held_nxt;
            row_n     <= ~(4'b0001 << row_idx_nxt);
        end
    end

    always_comb begin
        state_nxt     = state;
        row_idx_nxt   = row_idx;
        cnt_nxt       = cnt;
        cand_row_nxt  = cand_row;
        cand_cols_nxt = cand_cols;
        code_nxt      = code;
        key_valid_nxt = 1'b0;
        key_held_nxt  = key_held;
        case (state)
            ST_SCAN: begin
                if (cnt == SCAN_LAST) begin
                    cnt_nxt = '0;
                    if (single) begin
                        cand_row_nxt  = row_idx;
                        cand_cols_nxt = cols;
                        state_nxt     = ST_DEBOUNCE;
                    end else begin
                        row_idx_nxt = row_idx + 2'd1;
                    end
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            ST_DEBOUNCE: begin
                if (cols != cand_cols) begin
                    cnt_nxt     = '0;
                    row_idx_nxt = row_idx + 2'd1;
                    state_nxt   = ST_SCAN;
                end else if (cnt_inc == DEB_LAST) begin
                    code_nxt      = key_code(cand_row, cand_cols);
                    key_valid_nxt = 1'b1;
                    key_held_nxt  = 1'b1;
                    cnt_nxt       = '0;
                    state_nxt     = ST_PRESSED;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            ST_PRESSED: begin
                // Only a full-width all-high run of DEBOUNCE cycles ends the press.
                if (cols != 4'b1111) begin
                    cnt_nxt = '0;
                end else if (cnt_inc == DEB_LAST) begin
                    key_held_nxt = 1'b0;
                    row_idx_nxt  = row_idx + 2'd1;
                    cnt_nxt      = '0;
                    state_nxt    = ST_SCAN;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt = ST_SCAN;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign {x3, x2, x1, x0} = code;

endmodule

// File: tb/tb_keypad_encoder.sv
// Self-checking bench for keypad_encoder with a behavioural 4x4 keypad model.
module tb_keypad_encoder;

    logic       clk = 1'b0;
    logic       resetn;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic       x3, x2, x1, x0;
    logic       key_valid, key_held;
    logic [15:0] keys;   // bit r*4+c = key (r,c) pressed

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    typedef struct {
        int         r;
        int         c;
        logic [3:0] code;
    } vec_t;
    vec_t vecs [16];

    keypad_encoder #(.SCAN_DIV(4), .DEBOUNCE(8), .CNT_W(20)) dut (
        .clk(clk), .resetn(resetn), .col_n(col_n), .row_n(row_n),
        .x3(x3), .x2(x2), .x1(x1), .x0(x0),
        .key_valid(key_valid), .key_held(key_held)
    );

    always #5 clk = ~clk;

    // Pressed key on a driven row pulls its column low.
    always_comb begin
        col_n = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
    end

    always @(negedge clk) if (key_valid) pulses++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (key_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_release(output int n);
        n = 50;
        for (int i = 1; i < 50; i++) begin
            @(negedge clk);
            if (!key_held) begin
                n = i;
                break;
            end
        end
    endtask

    function automatic logic [3:0] row_pat(input int r);
        return 4'b1111 ^ (4'b0001 << r[1:0]);
    endfunction

    initial begin
        bit ok;
        int n;
        int base;
        vecs[0]  = '{0, 0, 4'h1}; vecs[1]  = '{0, 1, 4'h2}; vecs[2]  = '{0, 2, 4'h3}; vecs[3]  = '{0, 3, 4'hA};
        vecs[4]  = '{1, 0, 4'h4}; vecs[5]  = '{1, 1, 4'h5}; vecs[6]  = '{1, 2, 4'h6}; vecs[7]  = '{1, 3, 4'hB};
        vecs[8]  = '{2, 0, 4'h7}; vecs[9]  = '{2, 1, 4'h8}; vecs[10] = '{2, 2, 4'h9}; vecs[11] = '{2, 3, 4'hC};
        vecs[12] = '{3, 0, 4'hE}; vecs[13] = '{3, 1, 4'h0}; vecs[14] = '{3, 2, 4'hF}; vecs[15] = '{3, 3, 4'hD};

        keys   = 16'h0;
        resetn = 1'b0;
        tick(3);
        check("rst_row_n", 32'(row_n), 32'(4'b1110));
        check("rst_code", 32'({x3, x2, x1, x0}), 32'h0);
        check("rst_valid", 32'(key_valid), 32'h0);
        check("rst_held", 32'(key_held), 32'h0);

        // Idle scan: row advances every 4 clocks.
        base   = pulses;
        resetn = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check($sformatf("scan_row_k%0d", k), 32'(row_n), 32'(row_pat((k / 4) % 4)));
        end
        check("idle_no_pulse", 32'(pulses - base), 32'h0);
        check("idle_code", 32'({x3, x2, x1, x0}), 32'h0);

        // Key "5": exact release timing (2 sync + 8 debounce) and row resume.
        base    = pulses;
        keys[5] = 1'b1;
        wait_valid(ok);
        check("k5_valid_seen", 32'(ok), 32'h1);
        check("k5_code", 32'({x3, x2, x1, x0}), 32'h5);
        check("k5_held", 32'(key_held), 32'h1);
        tick(20);
        check("k5_row_hold", 32'(row_n), 32'(4'b1101));
        check("k5_held_still", 32'(key_held), 32'h1);
        check("k5_one_pulse", 32'(pulses - base), 32'h1);
        keys = 16'h0;
        wait_release(n);
        check("k5_release_cycles", 32'(n), 32'd10);
        check("k5_row_resume", 32'(row_n), 32'(4'b1011));
        check("k5_code_kept", 32'({x3, x2, x1, x0}), 32'h5);
        tick(3);

        // Every key position through the code map.
        foreach (vecs[i]) begin
            base = pulses;
            keys = 16'h0;
            keys[vecs[i].r*4 + vecs[i].c] = 1'b1;
            wait_valid(ok);
            check($sformatf("tbl%0d_valid_seen", i), 32'(ok), 32'h1);
            check($sformatf("tbl%0d_code", i), 32'({x3, x2, x1, x0}), 32'(vecs[i].code));
            tick(12);
            check($sformatf("tbl%0d_row_hold", i), 32'(row_n), 32'(row_pat(vecs[i].r)));
            check($sformatf("tbl%0d_one_pulse", i), 32'(pulses - base), 32'h1);
            keys = 16'h0;
            wait_release(n);
            check($sformatf("tbl%0d_release", i), 32'(n), 32'd10);
            check($sformatf("tbl%0d_next_row", i), 32'(row_n), 32'(row_pat((vecs[i].r + 1) % 4)));
            tick(3);
        end

        // "#" bouncing around its row scan, then steady.
        base = pulses;
        ok   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (row_n == 4'b0111) begin
                ok = 1'b1;
                break;
            end
        end
        check("bounce_row3_seen", 32'(ok), 32'h1);
        keys[14] = 1'b1; tick(5);
        keys[14] = 1'b0; tick(1);
        keys[14] = 1'b1; tick(1);
        keys[14] = 1'b0; tick(1);
        check("bounce_no_pulse", 32'(pulses - base), 32'h0);
        keys[14] = 1'b1;
        wait_valid(ok);
        check("bounce_valid_seen", 32'(ok), 32'h1);
        check("bounce_code", 32'({x3, x2, x1, x0}), 32'hF);
        tick(10);
        check("bounce_one_pulse", 32'(pulses - base), 32'h1);
        keys = 16'h0;
        wait_release(n);
        check("bounce_release", 32'(n), 32'd10);
        tick(3);

        // Hold "A", add "7" while pressed: only A is reported.
        base    = pulses;
        keys[3] = 1'b1;
        wait_valid(ok);
        check("a7_valid_seen", 32'(ok), 32'h1);
        check("a7_code", 32'({x3, x2, x1, x0}), 32'hA);
        tick(2);
        keys[8] = 1'b1;
        tick(30);
        check("a7_held", 32'(key_held), 32'h1);
        check("a7_code_kept", 32'({x3, x2, x1, x0}), 32'hA);
        keys = 16'h0;
        wait_release(n);
        check("a7_release", 32'(n), 32'd10);
        tick(40);
        check("a7_one_pulse", 32'(pulses - base), 32'h1);

        // "1" and "2" together from idle: two low columns, never a key.
        base = pulses;
        keys = 16'h0003;
        tick(60);
        check("two_key_no_pulse", 32'(pulses - base), 32'h0);
        check("two_key_not_held", 32'(key_held), 32'h0);
        keys = 16'h0;
        tick(5);

        // Release glitch of 5 cycles while pressed.
        base    = pulses;
        keys[5] = 1'b1;
        wait_valid(ok);
        check("glitch_valid_seen", 32'(ok), 32'h1);
        tick(3);
        keys[5] = 1'b0;
        tick(5);
        keys[5] = 1'b1;
        tick(15);
        check("glitch_held", 32'(key_held), 32'h1);
        check("glitch_one_pulse", 32'(pulses - base), 32'h1);
        keys = 16'h0;
        wait_release(n);
        check("glitch_release", 32'(n), 32'd10);
        tick(3);

        // Reset mid-press with "9" held; the key is detected again afterwards.
        base     = pulses;
        keys[10] = 1'b1;
        wait_valid(ok);
        check("rst9_valid_seen", 32'(ok), 32'h1);
        check("rst9_code", 32'({x3, x2, x1, x0}), 32'h9);
        tick(4);
        resetn = 1'b0;
        #1;
        check("rst9_async_row", 32'(row_n), 32'(4'b1110));
        check("rst9_async_code", 32'({x3, x2, x1, x0}), 32'h0);
        check("rst9_async_held", 32'(key_held), 32'h0);
        check("rst9_async_valid", 32'(key_valid), 32'h0);
        tick(2);
        resetn = 1'b1;
        wait_valid(ok);
        check("rst9_revalid_seen", 32'(ok), 32'h1);
        check("rst9_recode", 32'({x3, x2, x1, x0}), 32'h9);
        tick(5);
        check("rst9_two_pulses", 32'(pulses - base), 32'h2);
        keys = 16'h0;
        wait_release(n);
        check("rst9_release", 32'(n), 32'd10);
        tick(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
